// File: rtl/psum_ofifo_pkg.sv
// Shared sizing for the mac_array south-edge output collector.
package psum_ofifo_pkg;

  localparam int PSUM_BW = 32;
  localparam int COL     = 2;
  localparam int DEPTH   = 8;

  // Pointer width for a queue of d entries; the count needs one extra bit.
  function automatic int clog2(input int d);
    return $clog2(d);
  endfunction

endpackage

// File: rtl/psum_ofifo_if.sv
// Column psum stream from mac_array plus the downstream row-read handshake.
interface psum_ofifo_if
  import psum_ofifo_pkg::*;
#(
  parameter int psum_bw = PSUM_BW,
  parameter int col     = COL
);

  logic [psum_bw*col-1:0] in_s;
  logic [col-1:0]         valid_in;
  logic                   rd;
  logic [psum_bw*col-1:0] out;
  logic                   o_valid;
  logic                   o_full;
  logic                   overflow;

  // Environment side: mac_array feeding columns and the downstream reader.
  modport master (
    output in_s, valid_in, rd,
    input  out, o_valid, o_full, overflow
  );

  // Collector side.
  modport slave (
    input  in_s, valid_in, rd,
    output out, o_valid, o_full, overflow
  );

endinterface

// File: rtl/psum_ofifo_col_queue.sv
// Single-column circular FIFO, first-word fall-through.
module psum_col_queue
  import psum_ofifo_pkg::*;
#(
  parameter int psum_bw = PSUM_BW,
  parameter int depth   = DEPTH
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               wr,
  input  logic [psum_bw-1:0] din,
  input  logic               pop,
  output logic [psum_bw-1:0] dout,
  output logic               empty,
  output logic               full,
  output logic               drop
);

  localparam int PW = clog2(depth);
  localparam int CW = PW + 1;

  logic [psum_bw-1:0] mem_q [depth];
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               wr_acc;

  assign empty  = (cnt_q == '0);
  assign full   = (cnt_q == CW'(depth));
  // A pop on the same edge frees the slot, so a full queue still accepts.
  assign wr_acc = wr & (~full | pop);
  assign drop   = wr & full & ~pop;
  assign dout   = mem_q[rd_ptr_q];

  // Next pointers and count; power-of-two depth lets pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)    rd_ptr_d = rd_ptr_q + 1'b1;
    if (wr_acc && !pop)      cnt_d = cnt_q + 1'b1;
    else if (pop && !wr_acc) cnt_d = cnt_q - 1'b1;
  end

  // Pointer and count registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage array; contents need no reset because empty entries are never shown.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/psum_ofifo.sv
// Aligns skewed per-column psums into row vectors for downstream storage.
module psum_ofifo
  import psum_ofifo_pkg::*;
#(
  parameter int psum_bw = PSUM_BW,
  parameter int col     = COL,
  parameter int depth   = DEPTH
) (
  input logic          clk,
  input logic          reset_n,
  psum_ofifo_if.slave  bus
);

  logic [psum_bw-1:0] head_w [col];
  logic [col-1:0]     empty_w, full_w, drop_w;
  logic               o_valid_w, pop_w;
  logic               overflow_q, overflow_d;

  assign o_valid_w = ~|empty_w;
  assign pop_w     = bus.rd & o_valid_w;

  for (genvar j = 0; j < col; j++) begin : g_col
    psum_col_queue #(
      .psum_bw (psum_bw),
      .depth   (depth)
    ) u_q (
      .clk     (clk),
      .reset_n (reset_n),
      .wr      (bus.valid_in[j]),
      .din     (bus.in_s[psum_bw*j +: psum_bw]),
      .pop     (pop_w),
      .dout    (head_w[j]),
      .empty   (empty_w[j]),
      .full    (full_w[j]),
      .drop    (drop_w[j])
    );
  end

  // Head row, forced to zero until every column has data.
  always_comb begin
    bus.out = '0;
    if (o_valid_w) begin
      for (int j = 0; j < col; j++) bus.out[psum_bw*j +: psum_bw] = head_w[j];
    end
  end

  assign bus.o_valid  = o_valid_w;
  assign bus.o_full   = |full_w;
  assign bus.overflow = overflow_q;

  // Any dropped beat latches the error flag until reset.
  always_comb overflow_d = overflow_q | (|drop_w);

  // Sticky overflow register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) overflow_q <= 1'b0;
    else          overflow_q <= overflow_d;
  end

endmodule

// File: tb/tb_psum_ofifo.sv
// Directed bench for the psum output collector.
module tb_psum_ofifo;
  import psum_ofifo_pkg::*;

  logic clk;
  logic reset_n;
  int   n_assert;
  int   n_fail;

  psum_ofifo_if #(.psum_bw(PSUM_BW), .col(COL)) bus ();

  psum_ofifo #(.psum_bw(PSUM_BW), .col(COL), .depth(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [31:0] c1, input logic [31:0] c0, input logic r);
    bus.valid_in = v;
    bus.in_s     = {c1, c0};
    bus.rd       = r;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    drive(2'b11, 32'h1234_5678, 32'h9abc_def0, 1'b0);
    tick();
    tick();
    chk("rst_o_valid", 64'(bus.o_valid), 64'd0);
    chk("rst_o_full", 64'(bus.o_full), 64'd0);
    chk("rst_out", bus.out, 64'd0);
    chk("rst_overflow", 64'(bus.overflow), 64'd0);
    #2 reset_n = 1'b1;

    // Idle reads are ignored.
    drive(2'b00, 32'd0, 32'd0, 1'b1);
    for (int i = 0; i < 4; i++) tick();
    chk("idle_o_valid", 64'(bus.o_valid), 64'd0);
    chk("idle_overflow", 64'(bus.overflow), 64'd0);
    chk("idle_out", bus.out, 64'd0);

    // Skewed alignment: col0 first, col1 one cycle later.
    drive(2'b01, 32'd0, 32'd180, 1'b0);
    tick();
    chk("skew_half_valid", 64'(bus.o_valid), 64'd0);
    chk("skew_half_out", bus.out, 64'd0);
    drive(2'b10, 32'hFFFF_FF4C, 32'd0, 1'b0);
    tick();
    chk("skew_valid", 64'(bus.o_valid), 64'd1);
    chk("skew_out", bus.out, {32'hFFFF_FF4C, 32'd180});
    drive(2'b00, 32'd0, 32'd0, 1'b1);
    tick();
    chk("skew_drain", 64'(bus.o_valid), 64'd0);
    chk("skew_drain_out", bus.out, 64'd0);

    // Streaming 8 rows, col1 one cycle behind, rd held high.
    for (int k = 0; k < 9; k++) begin
      drive({(k >= 1) ? 1'b1 : 1'b0, (k < 8) ? 1'b1 : 1'b0},
            32'(200 + k - 1), 32'(100 + k), 1'b1);
      tick();
      if (k == 0) chk("stream_first", 64'(bus.o_valid), 64'd0);
      else begin
        chk($sformatf("stream_v%0d", k), 64'(bus.o_valid), 64'd1);
        chk($sformatf("stream_row%0d", k), bus.out, {32'(200 + k - 1), 32'(100 + k - 1)});
      end
    end
    drive(2'b00, 32'd0, 32'd0, 1'b1);
    tick();
    chk("stream_end", 64'(bus.o_valid), 64'd0);

    // Fill to full, then one dropped beat.
    for (int i = 0; i < 8; i++) begin
      drive(2'b11, 32'(20 + i), 32'(10 + i), 1'b0);
      tick();
      if (i == 6) chk("fill_not_full", 64'(bus.o_full), 64'd0);
    end
    chk("fill_full", 64'(bus.o_full), 64'd1);
    chk("fill_no_ovf", 64'(bus.overflow), 64'd0);
    drive(2'b11, 32'd99, 32'd99, 1'b0);
    tick();
    chk("ovf_set", 64'(bus.overflow), 64'd1);
    chk("ovf_full", 64'(bus.o_full), 64'd1);
    drive(2'b00, 32'd0, 32'd0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("ovf_row%0d", i), bus.out, {32'(20 + i), 32'(10 + i)});
      tick();
    end
    chk("ovf_empty", 64'(bus.o_valid), 64'd0);
    chk("ovf_sticky", 64'(bus.overflow), 64'd1);
    chk("ovf_not_full", 64'(bus.o_full), 64'd0);

    // Clear the sticky flag between edges.
    reset_n = 1'b0;
    #2 reset_n = 1'b1;
    chk("clr_overflow", 64'(bus.overflow), 64'd0);

    // Write into full queues while popping.
    for (int i = 0; i < 8; i++) begin
      drive(2'b11, 32'(40 + i), 32'(30 + i), 1'b0);
      tick();
    end
    drive(2'b11, 32'hFFFF_FFF9, 32'd7, 1'b1);
    tick();
    chk("wfp_overflow", 64'(bus.overflow), 64'd0);
    chk("wfp_full", 64'(bus.o_full), 64'd1);
    drive(2'b00, 32'd0, 32'd0, 1'b1);
    for (int i = 1; i < 8; i++) begin
      chk($sformatf("wfp_row%0d", i), bus.out, {32'(40 + i), 32'(30 + i)});
      tick();
    end
    chk("wfp_last", bus.out, {32'hFFFF_FFF9, 32'd7});
    tick();
    chk("wfp_empty", 64'(bus.o_valid), 64'd0);

    // Async reset with rows queued.
    for (int i = 1; i <= 3; i++) begin
      drive(2'b11, 32'(10 + i), 32'(i), 1'b0);
      tick();
    end
    chk("ar_valid", 64'(bus.o_valid), 64'd1);
    chk("ar_head", bus.out, {32'd11, 32'd1});
    #2 reset_n = 1'b0;
    #1;
    chk("ar_o_valid", 64'(bus.o_valid), 64'd0);
    chk("ar_out", bus.out, 64'd0);
    #1 reset_n = 1'b1;
    drive(2'b11, 32'hFFFF_FFFB, 32'd5, 1'b0);
    tick();
    chk("ar_new_valid", 64'(bus.o_valid), 64'd1);
    chk("ar_new_row", bus.out, {32'hFFFF_FFFB, 32'd5});
    drive(2'b00, 32'd0, 32'd0, 1'b1);
    tick();
    chk("ar_new_drain", 64'(bus.o_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
